// File: rtl/md5_pkg.sv
`default_nettype none
//============================================================================
// Module   : md5_pkg
// Desc     : Shared definitions for the MD5 compression core: controller
//            state encoding, MD5 initial chaining values, and the per-round
//            additive constant K[i] and rotate amount S[i] lookups.
// Revision : 1.0 - initial release
//============================================================================
package md5_pkg;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_RUN  = 2'd1;
    localparam state_t c_DONE = 2'd2;

    // MD5 initial chaining values
    localparam logic [31:0] c_INIT_A = 32'h67452301;
    localparam logic [31:0] c_INIT_B = 32'hefcdab89;
    localparam logic [31:0] c_INIT_C = 32'h98badcfe;
    localparam logic [31:0] c_INIT_D = 32'h10325476;

    // K[i] = floor(abs(sin(i+1)) * 2^32)
    function automatic logic [31:0] md5_k(input logic [5:0] i);
        logic [31:0] k;
        case (i)
            6'd0:  k = 32'hd76aa478;  6'd1:  k = 32'he8c7b756;
            6'd2:  k = 32'h242070db;  6'd3:  k = 32'hc1bdceee;
            6'd4:  k = 32'hf57c0faf;  6'd5:  k = 32'h4787c62a;
            6'd6:  k = 32'ha8304613;  6'd7:  k = 32'hfd469501;
            6'd8:  k = 32'h698098d8;  6'd9:  k = 32'h8b44f7af;
            6'd10: k = 32'hffff5bb1;  6'd11: k = 32'h895cd7be;
            6'd12: k = 32'h6b901122;  6'd13: k = 32'hfd987193;
            6'd14: k = 32'ha679438e;  6'd15: k = 32'h49b40821;
            6'd16: k = 32'hf61e2562;  6'd17: k = 32'hc040b340;
            6'd18: k = 32'h265e5a51;  6'd19: k = 32'he9b6c7aa;
            6'd20: k = 32'hd62f105d;  6'd21: k = 32'h02441453;
            6'd22: k = 32'hd8a1e681;  6'd23: k = 32'he7d3fbc8;
            6'd24: k = 32'h21e1cde6;  6'd25: k = 32'hc33707d6;
            6'd26: k = 32'hf4d50d87;  6'd27: k = 32'h455a14ed;
            6'd28: k = 32'ha9e3e905;  6'd29: k = 32'hfcefa3f8;
            6'd30: k = 32'h676f02d9;  6'd31: k = 32'h8d2a4c8a;
            6'd32: k = 32'hfffa3942;  6'd33: k = 32'h8771f681;
            6'd34: k = 32'h6d9d6122;  6'd35: k = 32'hfde5380c;
            6'd36: k = 32'ha4beea44;  6'd37: k = 32'h4bdecfa9;
            6'd38: k = 32'hf6bb4b60;  6'd39: k = 32'hbebfbc70;
            6'd40: k = 32'h289b7ec6;  6'd41: k = 32'heaa127fa;
            6'd42: k = 32'hd4ef3085;  6'd43: k = 32'h04881d05;
            6'd44: k = 32'hd9d4d039;  6'd45: k = 32'he6db99e5;
            6'd46: k = 32'h1fa27cf8;  6'd47: k = 32'hc4ac5665;
            6'd48: k = 32'hf4292244;  6'd49: k = 32'h432aff97;
            6'd50: k = 32'hab9423a7;  6'd51: k = 32'hfc93a039;
            6'd52: k = 32'h655b59c3;  6'd53: k = 32'h8f0ccc92;
            6'd54: k = 32'hffeff47d;  6'd55: k = 32'h85845dd1;
            6'd56: k = 32'h6fa87e4f;  6'd57: k = 32'hfe2ce6e0;
            6'd58: k = 32'ha3014314;  6'd59: k = 32'h4e0811a1;
            6'd60: k = 32'hf7537e82;  6'd61: k = 32'hbd3af235;
            6'd62: k = 32'h2ad7d2bb;
            default: k = 32'heb86d391;
        endcase
        return k;
    endfunction

    // S[i]: the shift pattern repeats every four rounds within each
    // 16-round group, so only the group and the position modulo 4 matter.
    function automatic logic [4:0] md5_s(input logic [5:0] i);
        logic [4:0] s;
        case ({i[5:4], i[1:0]})
            4'b00_00: s = 5'd7;   4'b00_01: s = 5'd12;
            4'b00_10: s = 5'd17;  4'b00_11: s = 5'd22;
            4'b01_00: s = 5'd5;   4'b01_01: s = 5'd9;
            4'b01_10: s = 5'd14;  4'b01_11: s = 5'd20;
            4'b10_00: s = 5'd4;   4'b10_01: s = 5'd11;
            4'b10_10: s = 5'd16;  4'b10_11: s = 5'd23;
            4'b11_00: s = 5'd6;   4'b11_01: s = 5'd10;
            4'b11_10: s = 5'd15;
            default:  s = 5'd21;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md5_round.sv
`default_nettype none
//============================================================================
// Module   : md5_round
// Desc     : Combinational single MD5 step. Given the round index, the four
//            working values and the 16-word message block, produces the
//            working values after that round.
// Ports    : i_idx        round index 0..63
//            i_a..i_d     working values entering the round
//            i_m          message block, word j = i_m[32j+31:32j]
//            o_a..o_d     working values leaving the round
// Revision : 1.0 - initial release
//============================================================================
module md5_round
    import md5_pkg::*;
(
    input  logic [5:0]   i_idx,
    input  logic [31:0]  i_a,
    input  logic [31:0]  i_b,
    input  logic [31:0]  i_c,
    input  logic [31:0]  i_d,
    input  logic [511:0] i_m,
    output logic [31:0]  o_a,
    output logic [31:0]  o_b,
    output logic [31:0]  o_c,
    output logic [31:0]  o_d
);

    logic [31:0] w_f;
    logic [3:0]  w_g;
    logic [3:0]  w_i4;
    logic [31:0] w_sum;
    logic [63:0] w_dbl;
    logic [31:0] w_rot;

    assign w_i4 = i_idx[3:0];

    // Boolean function and message word index per 16-round group. The
    // index formulas only need i mod 16 because 16*n vanishes mod 16.
    always_comb begin
        w_f = 32'd0;
        w_g = 4'd0;
        case (i_idx[5:4])
            2'd0: begin
                w_f = (i_b & i_c) | (~i_b & i_d);
                w_g = w_i4;
            end
            2'd1: begin
                w_f = (i_d & i_b) | (~i_d & i_c);
                w_g = w_i4 * 4'd5 + 4'd1;
            end
            2'd2: begin
                w_f = i_b ^ i_c ^ i_d;
                w_g = w_i4 * 4'd3 + 4'd5;
            end
            default: begin
                w_f = i_c ^ (i_b | ~i_d);
                w_g = w_i4 * 4'd7;
            end
        endcase
    end

    assign w_sum = i_a + w_f + md5_k(i_idx) + i_m[32*w_g +: 32];

    // Rotate-left via a doubled word: the upper half of {x,x}<<s is rotl(x,s)
    assign w_dbl = {w_sum, w_sum} << md5_s(i_idx);
    assign w_rot = w_dbl[63:32];

    assign o_a = i_d;
    assign o_b = i_b + w_rot;
    assign o_c = i_b;
    assign o_d = i_c;

endmodule
`default_nettype wire

// File: rtl/md5_update.sv
`default_nettype none
//============================================================================
// Module   : md5_update
// Desc     : Multi-cycle MD5 compression of one 512-bit block. Latches the
//            block and chaining values on a start request, runs 64 rounds,
//            then publishes the final working values a..d (no feed-forward;
//            the caller adds them to A..D) and toggles 'complete'.
// Ports    : clk        system clock
//            reset      synchronous active-high reset
//            str        message block (the natural name 'string' is a
//                       SystemVerilog keyword); word j = str[32j+31:32j]
//            en         level start request; needs a low cycle between blocks
//            input_len  block byte count, reserved and not used for hashing
//            A..D       chaining values, sampled at start only
//            complete   toggles once per finished block
//            a..d       final working values, held until the next block ends
// Config   : MD5_UNROLL2_EN - two chained rounds per clock (32-cycle RUN)
// Revision : 1.0 - initial release
//============================================================================
module md5_update
    import md5_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [511:0] str,
    input  logic         en,
    input  logic [8:0]   input_len,
    input  logic [31:0]  A,
    input  logic [31:0]  B,
    input  logic [31:0]  C,
    input  logic [31:0]  D,
    output logic         complete,
    output logic [31:0]  a,
    output logic [31:0]  b,
    output logic [31:0]  c,
    output logic [31:0]  d
);

`ifdef MD5_UNROLL2_EN
    localparam logic [5:0] c_STEP       = 6'd2;
    localparam logic [5:0] c_LAST_ROUND = 6'd62;
`else
    localparam logic [5:0] c_STEP       = 6'd1;
    localparam logic [5:0] c_LAST_ROUND = 6'd63;
`endif

    state_t         r_state;
    state_t         w_state_next;
    logic           w_start;
    logic           r_armed;
    logic [5:0]     r_round;
    logic [31:0]    r_wa, r_wb, r_wc, r_wd;
    logic [511:0]   r_m;
    logic [31:0]    w_nxt_a, w_nxt_b, w_nxt_c, w_nxt_d;
    logic           w_unused_len;

    assign w_unused_len = ^input_len;

    //------------------------------------------------------------------
    // Round datapath
    //------------------------------------------------------------------
    logic [31:0] w_r0_a, w_r0_b, w_r0_c, w_r0_d;

    md5_round u_round0 (
        .i_idx (r_round),
        .i_a   (r_wa),
        .i_b   (r_wb),
        .i_c   (r_wc),
        .i_d   (r_wd),
        .i_m   (r_m),
        .o_a   (w_r0_a),
        .o_b   (w_r0_b),
        .o_c   (w_r0_c),
        .o_d   (w_r0_d)
    );

`ifdef MD5_UNROLL2_EN
    // The counter only holds even indices here; the second stage runs
    // the odd round that immediately follows.
    logic [31:0] w_r1_a, w_r1_b, w_r1_c, w_r1_d;

    md5_round u_round1 (
        .i_idx ({r_round[5:1], 1'b1}),
        .i_a   (w_r0_a),
        .i_b   (w_r0_b),
        .i_c   (w_r0_c),
        .i_d   (w_r0_d),
        .i_m   (r_m),
        .o_a   (w_r1_a),
        .o_b   (w_r1_b),
        .o_c   (w_r1_c),
        .o_d   (w_r1_d)
    );

    assign w_nxt_a = w_r1_a;
    assign w_nxt_b = w_r1_b;
    assign w_nxt_c = w_r1_c;
    assign w_nxt_d = w_r1_d;
`else
    assign w_nxt_a = w_r0_a;
    assign w_nxt_b = w_r0_b;
    assign w_nxt_c = w_r0_c;
    assign w_nxt_d = w_r0_d;
`endif

    //------------------------------------------------------------------
    // Controller
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (en && r_armed) begin
                    w_start      = 1'b1;
                    w_state_next = c_RUN;
                end
            end
            c_RUN: begin
                if (r_round == c_LAST_ROUND) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Working registers, arming and outputs
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed  <= 1'b1;
            r_round  <= 6'd0;
            r_wa     <= 32'd0;
            r_wb     <= 32'd0;
            r_wc     <= 32'd0;
            r_wd     <= 32'd0;
            r_m      <= 512'd0;
            complete <= 1'b0;
            a        <= 32'd0;
            b        <= 32'd0;
            c        <= 32'd0;
            d        <= 32'd0;
        end else begin
            // Any low cycle re-arms; a start consumes the arm so a held
            // en cannot launch a second block.
            if (!en) begin
                r_armed <= 1'b1;
            end

            if (w_start) begin
                r_armed <= 1'b0;
                r_round <= 6'd0;
                r_m     <= str;
                r_wa    <= A;
                r_wb    <= B;
                r_wc    <= C;
                r_wd    <= D;
            end

            if (r_state == c_RUN) begin
                r_wa    <= w_nxt_a;
                r_wb    <= w_nxt_b;
                r_wc    <= w_nxt_c;
                r_wd    <= w_nxt_d;
                r_round <= r_round + c_STEP;
            end

            if (r_state == c_DONE) begin
                a        <= r_wa;
                b        <= r_wb;
                c        <= r_wc;
                d        <= r_wd;
                complete <= ~complete;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md5_update.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : tb_md5_update
// Desc     : Self-checking bench for md5_update. Stimulus pushes expected
//            results (values and completion cycle) into a scoreboard; a
//            negedge monitor pops on every 'complete' toggle and checks that
//            outputs hold steady between toggles.
// Config   : MD5_UNROLL2_EN selects the 33-cycle latency expectation
// Revision : 1.0 - initial release
//============================================================================
module tb_md5_update;

`ifdef MD5_UNROLL2_EN
    localparam int c_LAT = 33;
`else
    localparam int c_LAT = 65;
`endif

    localparam logic [31:0] c_IA = 32'h67452301;
    localparam logic [31:0] c_IB = 32'hefcdab89;
    localparam logic [31:0] c_IC = 32'h98badcfe;
    localparam logic [31:0] c_ID = 32'h10325476;

    logic         clk;
    logic         reset;
    logic [511:0] str;
    logic         en;
    logic [8:0]   input_len;
    logic [31:0]  A, B, C, D;
    logic         complete;
    logic [31:0]  a, b, c, d;

    md5_update dut (
        .clk       (clk),
        .reset     (reset),
        .str       (str),
        .en        (en),
        .input_len (input_len),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .complete  (complete),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ea, eb, ec, ed;
        int          ecyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    //------------------------------------------------------------------
    // Reference model: textbook MD5 compression written from the
    // algorithm definition; K derived from the sine formula.
    //------------------------------------------------------------------
    logic [31:0] kt [64];
    int sh_tab [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                          '{4, 11, 16, 23}, '{6, 10, 15, 21}};

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    task automatic ref_md5(input logic [511:0] m,
                           input logic [31:0] ia, ib, ic, id,
                           output logic [31:0] oa, ob, oc, od);
        logic [31:0] wa, wb, wc, wd, f, t;
        logic [31:0] mw [16];
        int g;
        for (int j = 0; j < 16; j++) mw[j] = m[32*j +: 32];
        wa = ia; wb = ib; wc = ic; wd = id;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (wb & wc) | (~wb & wd); g = i;                end
                1: begin f = (wd & wb) | (~wd & wc); g = (5 * i + 1) % 16; end
                2: begin f = wb ^ wc ^ wd;           g = (3 * i + 5) % 16; end
                default: begin f = wc ^ (wb | ~wd);  g = (7 * i) % 16;     end
            endcase
            t  = wd;
            wd = wc;
            wc = wb;
            wb = wb + rotl(wa + f + kt[i] + mw[g], sh_tab[i / 16][i % 4]);
            wa = t;
        end
        oa = wa; ob = wb; oc = wc; od = wd;
    endtask

    //------------------------------------------------------------------
    // Monitor
    //------------------------------------------------------------------
    logic         prev_c;
    logic [127:0] last_out;

    always @(negedge clk) begin
        if (reset) begin
            prev_c   = complete;
            last_out = '0;
        end else if (complete !== prev_c) begin
            prev_c = complete;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_toggle actual=%b expected=no_toggle (cycle %0d)", complete, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_a", {96'd0, a}, {96'd0, e.ea});
                chk("result_b", {96'd0, b}, {96'd0, e.eb});
                chk("result_c", {96'd0, c}, {96'd0, e.ec});
                chk("result_d", {96'd0, d}, {96'd0, e.ed});
                chk("toggle_cycle", 128'(cyc), 128'(e.ecyc));
            end
            last_out = {a, b, c, d};
        end else begin
            chk("hold_outputs", {a, b, c, d}, last_out);
        end
    end

    //------------------------------------------------------------------
    // Stimulus helpers (inputs change 1ns after a rising edge)
    //------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_blk(input logic [511:0] m,
                             input logic [31:0] ia, ib, ic, id,
                             input logic [31:0] ea, eb, ec, ed,
                             input bit push);
        exp_t e;
        str = m; A = ia; B = ib; C = ic; D = id;
        en  = 1'b1;
        if (push) begin
            e.ea = ea; e.eb = eb; e.ec = ec; e.ed = ed;
            e.ecyc = cyc + 1 + c_LAT;
            sb.push_back(e);
        end
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < c_LAT + 200) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
            sb.delete();
        end
        repeat (2) step();
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] m;
        for (int w = 0; w < 16; w++) m[32*w +: 32] = $urandom();
        return m;
    endfunction

    //------------------------------------------------------------------
    // Main sequence
    //------------------------------------------------------------------
    logic [511:0] m_empty, m_abc;
    logic [31:0]  e1a, e1b, e1c, e1d;

    initial begin
        for (int i = 0; i < 64; i++) begin
            real r;
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            r = $floor(r * 4294967296.0);
            kt[i] = 32'(longint'(r));
        end

        m_empty = 512'h80;
        m_abc   = '0;
        m_abc[31:0]    = 32'h80636261;
        m_abc[511:448] = 64'd24;

        // Expected raw outputs derived from the known digests minus A..D
        e1a = 32'hd98c1dd4 - c_IA;
        e1b = 32'h04b2008f - c_IB;
        e1c = 32'h980980e9 - c_IC;
        e1d = 32'h7e42f8ec - c_ID;

        reset = 1'b1; en = 1'b0; str = '0; input_len = '0;
        A = '0; B = '0; C = '0; D = '0;
        repeat (3) step();
        chk("reset_complete", 128'(complete), 128'd0);
        chk("reset_outputs", {a, b, c, d}, 128'd0);
        reset = 1'b0;
        step();

        // Empty message
        input_len = 9'd0;
        start_blk(m_empty, c_IA, c_IB, c_IC, c_ID, e1a, e1b, e1c, e1d, 1'b1);
        en = 1'b0;
        drain();

        // "abc"
        input_len = 9'd3;
        start_blk(m_abc, c_IA, c_IB, c_IC, c_ID,
                  32'h98500190 - c_IA, 32'hb04fd23c - c_IB,
                  32'h7d3f96d6 - c_IC, 32'h727fe128 - c_ID, 1'b1);
        en = 1'b0;
        drain();

        // Held en: one block only; a single low cycle re-arms
        start_blk(m_empty, c_IA, c_IB, c_IC, c_ID, e1a, e1b, e1c, e1d, 1'b1);
        repeat (199) step();
        en = 1'b0;
        step();
        start_blk(m_abc, c_IA, c_IB, c_IC, c_ID,
                  32'h98500190 - c_IA, 32'hb04fd23c - c_IB,
                  32'h7d3f96d6 - c_IC, 32'h727fe128 - c_ID, 1'b1);
        en = 1'b0;
        drain();

        // Inputs disturbed mid-run must not affect the result
        start_blk(m_empty, c_IA, c_IB, c_IC, c_ID, e1a, e1b, e1c, e1d, 1'b1);
        repeat (10) step();
        str = rand_blk();
        A = $urandom(); B = $urandom(); C = $urandom(); D = $urandom();
        repeat (5) step();
        en = 1'b0;
        drain();

        // Reset partway through the run, with en high during reset
        start_blk(m_abc, c_IA, c_IB, c_IC, c_ID, '0, '0, '0, '0, 1'b0);
        repeat (c_LAT / 2 - 2) step();
        reset = 1'b1;
        repeat (2) step();
        chk("midrun_reset_complete", 128'(complete), 128'd0);
        chk("midrun_reset_outputs", {a, b, c, d}, 128'd0);
        reset = 1'b0;
        en = 1'b0;
        step();
        start_blk(m_empty, c_IA, c_IB, c_IC, c_ID, e1a, e1b, e1c, e1d, 1'b1);
        en = 1'b0;
        drain();

        // Randomized blocks against the reference model
        for (int n = 0; n < 14; n++) begin
            logic [511:0] m;
            logic [31:0]  ia, ib, ic, id, oa, ob, oc, od;
            int hold;
            m  = rand_blk();
            ia = $urandom(); ib = $urandom(); ic = $urandom(); id = $urandom();
            ref_md5(m, ia, ib, ic, id, oa, ob, oc, od);
            input_len = 9'($urandom_range(0, 64));
            hold = $urandom_range(1, 90);
            start_blk(m, ia, ib, ic, id, oa, ob, oc, od, 1'b1);
            str = rand_blk();
            A = $urandom();
            repeat (hold - 1) step();
            en = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            drain();
        end

        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
